fsm: RTL and testbench



---
 rtl/fsm.sv | 62 ++++++
 tb/tb_fsm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fsm.sv
// Vending-machine controller: accumulates nickel credit, vends at 25 cents
// and returns any overpay as change, all outputs registered.
module fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] coin,
    output logic       vend,
    output logic [2:0] state,
    output logic [2:0] change
);

    localparam int unsigned SUM_W  = 4;
    localparam int unsigned COIN_W = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FIVE       = 3'd1,
        TEN        = 3'd2,
        FIFTEEN    = 3'd3,
        TWENTY     = 3'd4,
        TWENTYFIVE = 3'd5
    } state_t;

    localparam logic [SUM_W-1:0] PRICE = SUM_W'(5);

    state_t           cur;
    logic [SUM_W-1:0] coin_val_c;
    logic [SUM_W-1:0] credit_c;
    logic [SUM_W-1:0] sum_c;

    // Codes 6/7 are worthless; a completed sale leaves no carried credit.
    always_comb begin
        coin_val_c = '0;
        credit_c   = '0;
        if (coin <= COIN_W'(5)) begin
            coin_val_c = SUM_W'(coin);
        end
        if (cur != TWENTYFIVE) begin
            credit_c = SUM_W'(cur);
        end
        sum_c = credit_c + coin_val_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur    <= IDLE;
            vend   <= 1'b0;
            change <= '0;
        end else if (sum_c < PRICE) begin
            cur    <= state_t'(sum_c[2:0]);
            vend   <= 1'b0;
            change <= '0;
        end else begin
            cur    <= TWENTYFIVE;
            vend   <= 1'b1;
            change <= COIN_W'(sum_c - PRICE);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_fsm.sv
// Bench for the vending-machine controller: directed vector table followed by
// a random run checked against a reference model, through one scoreboard.
module tb_fsm;

    logic       clock;
    logic       reset;
    logic [2:0] coin;
    logic       vend;
    logic [2:0] state;
    logic [2:0] change;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic [2:0] cn;
        logic [2:0] st;
        logic       vd;
        logic [2:0] ch;
        string      tag;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic       vd;
        logic [2:0] ch;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic [2:0] m_state;

    fsm dut (
        .clock  (clock),
        .reset  (reset),
        .coin   (coin),
        .vend   (vend),
        .state  (state),
        .change (change)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check3(input string tag, input string what, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", tag, what, act, req);
        end
    endtask

    // Drive one edge's inputs, queue the expectation, and check after the edge.
    task automatic step(input logic r, input logic [2:0] c, input exp_t e);
        exp_t got;
        @(negedge clock);
        reset = r;
        coin  = c;
        sb.push_back(e);
        m_state = e.st;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", e.tag);
        end else begin
            got = sb.pop_front();
            check3(got.tag, "state",  int'(state),  int'(got.st));
            check3(got.tag, "vend",   int'(vend),   int'(got.vd));
            check3(got.tag, "change", int'(change), int'(got.ch));
        end
    endtask

    function automatic exp_t model(input logic r, input logic [2:0] c, input logic [2:0] s);
        exp_t e;
        int v;
        int cr;
        int sum;
        e.tag = "rand";
        if (r) begin
            e.st = 3'd0; e.vd = 1'b0; e.ch = 3'd0;
        end else begin
            v   = (c <= 3'd5) ? int'(c) : 0;
            cr  = (s == 3'd5) ? 0 : int'(s);
            sum = cr + v;
            if (sum >= 5) begin
                e.st = 3'd5; e.vd = 1'b1; e.ch = 3'(sum - 5);
            end else begin
                e.st = 3'(sum); e.vd = 1'b0; e.ch = 3'd0;
            end
        end
        return e;
    endfunction

    initial begin
        exp_t e;
        logic r;
        logic [2:0] c;
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        coin    = 3'd0;
        m_state = 3'd0;

        vecs.push_back('{1'b1, 3'd5, 3'd0, 1'b0, 3'd0, "reset_quarter"});
        vecs.push_back('{1'b0, 3'd1, 3'd1, 1'b0, 3'd0, "nick1"});
        vecs.push_back('{1'b0, 3'd1, 3'd2, 1'b0, 3'd0, "nick2"});
        vecs.push_back('{1'b0, 3'd1, 3'd3, 1'b0, 3'd0, "nick3"});
        vecs.push_back('{1'b0, 3'd1, 3'd4, 1'b0, 3'd0, "nick4"});
        vecs.push_back('{1'b0, 3'd1, 3'd5, 1'b1, 3'd0, "nick5_vend"});
        vecs.push_back('{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, "after_vend_idle"});
        vecs.push_back('{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, "idle_hold"});
        vecs.push_back('{1'b0, 3'd1, 3'd1, 1'b0, 3'd0, "ndq_n"});
        vecs.push_back('{1'b0, 3'd2, 3'd3, 1'b0, 3'd0, "ndq_d"});
        vecs.push_back('{1'b0, 3'd5, 3'd5, 1'b1, 3'd3, "ndq_q_change3"});
        vecs.push_back('{1'b0, 3'd1, 3'd1, 1'b0, 3'd0, "ndd_n"});
        vecs.push_back('{1'b0, 3'd2, 3'd3, 1'b0, 3'd0, "ndd_d"});
        vecs.push_back('{1'b0, 3'd2, 3'd5, 1'b1, 3'd0, "ndd_d_exact"});
        vecs.push_back('{1'b0, 3'd1, 3'd1, 1'b0, 3'd0, "n4d_1"});
        vecs.push_back('{1'b0, 3'd1, 3'd2, 1'b0, 3'd0, "n4d_2"});
        vecs.push_back('{1'b0, 3'd1, 3'd3, 1'b0, 3'd0, "n4d_3"});
        vecs.push_back('{1'b0, 3'd1, 3'd4, 1'b0, 3'd0, "n4d_4"});
        vecs.push_back('{1'b0, 3'd0, 3'd4, 1'b0, 3'd0, "twenty_hold"});
        vecs.push_back('{1'b0, 3'd2, 3'd5, 1'b1, 3'd1, "n4d_d_change1"});
        vecs.push_back('{1'b0, 3'd1, 3'd1, 1'b0, 3'd0, "n2q_1"});
        vecs.push_back('{1'b0, 3'd1, 3'd2, 1'b0, 3'd0, "n2q_2"});
        vecs.push_back('{1'b0, 3'd5, 3'd5, 1'b1, 3'd2, "n2q_q_change2"});
        vecs.push_back('{1'b0, 3'd1, 3'd1, 1'b0, 3'd0, "n3d_1"});
        vecs.push_back('{1'b0, 3'd1, 3'd2, 1'b0, 3'd0, "n3d_2"});
        vecs.push_back('{1'b0, 3'd1, 3'd3, 1'b0, 3'd0, "n3d_3"});
        vecs.push_back('{1'b0, 3'd2, 3'd5, 1'b1, 3'd0, "n3d_d_exact"});
        vecs.push_back('{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, "to_idle"});
        vecs.push_back('{1'b0, 3'd5, 3'd5, 1'b1, 3'd0, "quarter_idle"});
        vecs.push_back('{1'b0, 3'd2, 3'd2, 1'b0, 3'd0, "dime_after_vend"});
        vecs.push_back('{1'b0, 3'd6, 3'd2, 1'b0, 3'd0, "invalid6"});
        vecs.push_back('{1'b0, 3'd7, 3'd2, 1'b0, 3'd0, "invalid7"});
        vecs.push_back('{1'b0, 3'd2, 3'd4, 1'b0, 3'd0, "dd_twenty"});
        vecs.push_back('{1'b0, 3'd5, 3'd5, 1'b1, 3'd4, "max_overpay"});
        vecs.push_back('{1'b0, 3'd5, 3'd5, 1'b1, 3'd0, "back_to_back"});
        vecs.push_back('{1'b0, 3'd4, 3'd4, 1'b0, 3'd0, "dime_dime"});
        vecs.push_back('{1'b0, 3'd3, 3'd5, 1'b1, 3'd2, "nd_over"});
        vecs.push_back('{1'b0, 3'd3, 3'd3, 1'b0, 3'd0, "nd_from_vend"});
        vecs.push_back('{1'b0, 3'd7, 3'd3, 1'b0, 3'd0, "invalid7_hold"});
        vecs.push_back('{1'b0, 3'd1, 3'd4, 1'b0, 3'd0, "mid_four"});
        vecs.push_back('{1'b1, 3'd2, 3'd0, 1'b0, 3'd0, "reset_mid"});
        vecs.push_back('{1'b0, 3'd1, 3'd1, 1'b0, 3'd0, "post_reset_n"});

        for (int i = 0; i < vecs.size(); i++) begin
            e.st  = vecs[i].st;
            e.vd  = vecs[i].vd;
            e.ch  = vecs[i].ch;
            e.tag = vecs[i].tag;
            step(vecs[i].rst, vecs[i].cn, e);
        end

        // Hand sequence: reset on a vend cycle must cancel the pending sale.
        e = '{3'd4, 1'b0, 3'd0, "seq_d_twenty"};   step(1'b0, 3'd3, e);
        e = '{3'd5, 1'b1, 3'd1, "seq_d_vend"};     step(1'b0, 3'd2, e);
        e = '{3'd0, 1'b0, 3'd0, "seq_reset_q"};    step(1'b1, 3'd5, e);
        e = '{3'd0, 1'b0, 3'd0, "seq_reset_hold"}; step(1'b1, 3'd1, e);

        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) == 0);
            c = 3'($urandom_range(0, 7));
            e = model(r, c, m_state);
            step(r, c, e);
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
